// File: rtl/spu_mulred_arb.sv
// Arbiter/sequencer for the shared SPU multiply-reduce engine: queues start
// requests, grants round-robin between exp and mamul, and tracks each op.
module spu_mulred_arb #(
  parameter int TMO_W   = 10,
  parameter int TMO_MAX = 1023
) (
  input  logic       rclk,
  input  logic       reset,
  input  logic       se,
  input  logic       spu_maexp_start_mulred_aequb,
  input  logic       spu_maexp_start_mulred_anoteqb,
  input  logic       spu_mamul_start_mulred,
  input  logic       spu_mared_red_done,
  input  logic       spu_mactl_kill_op,
  output logic       spu_mulred_start,
  output logic       spu_mulred_aequb_sel,
  output logic [1:0] spu_mulred_owner,
  output logic       spu_mulred_busy,
  output logic       spu_mulred_exp_done,
  output logic       spu_mulred_mul_done,
  output logic       spu_mulred_abort,
  output logic       spu_mulred_tmo_err,
  output logic       spu_mulred_ovf_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_AEQ  = 2'b01;
  localparam logic [1:0] OWN_ANE  = 2'b10;
  localparam logic [1:0] OWN_MUL  = 2'b11;

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_MAX);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic             pa_q, pa_d;
  logic             pn_q, pn_d;
  logic             pm_q, pm_d;
  logic             last_cls_q, last_cls_d;  // 1: mamul granted last
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             tmo_err_q, tmo_err_d;
  logic             ovf_err_q, ovf_err_d;

  logic             exp_pend;
  logic             grant_vld;
  logic             pick_mul;
  logic [1:0]       grant_owner;
  logic             take_a, take_n, take_m;
  logic [TMO_W-1:0] cnt_inc;
  logic             kill;

  // Scan enable only reaches the flops in the physical netlist.
  logic unused_se;
  assign unused_se = se;

  assign kill = spu_mactl_kill_op;

  // Grant selection: exp class (anoteqb over aequb) round-robins against mamul.
  always_comb begin
    exp_pend    = pa_q | pn_q;
    grant_vld   = (state_q == ST_IDLE) && (exp_pend || pm_q) && !kill;
    pick_mul    = pm_q && (!exp_pend || !last_cls_q);
    grant_owner = pick_mul ? OWN_MUL : (pn_q ? OWN_ANE : OWN_AEQ);
    take_a      = grant_vld && (grant_owner == OWN_AEQ);
    take_n      = grant_vld && (grant_owner == OWN_ANE);
    take_m      = grant_vld && (grant_owner == OWN_MUL);
    cnt_inc     = cnt_q + TMO_W'(1);
  end

  // State register
  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      pa_q       <= 1'b0;
      pn_q       <= 1'b0;
      pm_q       <= 1'b0;
      last_cls_q <= 1'b1;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      tmo_err_q  <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      pa_q       <= pa_d;
      pn_q       <= pn_d;
      pm_q       <= pm_d;
      last_cls_q <= last_cls_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      tmo_err_q  <= tmo_err_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_cls_d = last_cls_q;
    cnt_d      = cnt_q;
    abort_d    = 1'b0;
    tmo_err_d  = tmo_err_q;

    // A new pulse beats consumption of its own flop; kill beats everything.
    pa_d = kill ? 1'b0 : (spu_maexp_start_mulred_aequb   | (pa_q & ~take_a));
    pn_d = kill ? 1'b0 : (spu_maexp_start_mulred_anoteqb | (pn_q & ~take_n));
    pm_d = kill ? 1'b0 : (spu_mamul_start_mulred         | (pm_q & ~take_m));

    ovf_err_d = ovf_err_q |
                (!kill && ((spu_maexp_start_mulred_aequb   && pa_q && !take_a) ||
                           (spu_maexp_start_mulred_anoteqb && pn_q && !take_n) ||
                           (spu_mamul_start_mulred         && pm_q && !take_m)));

    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d    = ST_LAUNCH;
          owner_d    = grant_owner;
          last_cls_d = pick_mul;
        end
      end
      ST_LAUNCH: begin
        cnt_d = '0;
        if (kill) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          abort_d = 1'b1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_inc;
        if (kill) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          abort_d = 1'b1;
        end else if (spu_mared_red_done) begin
          state_d = ST_DONE;
        end else if (cnt_inc == TMO_LIM) begin
          state_d   = ST_IDLE;
          owner_d   = OWN_NONE;
          abort_d   = 1'b1;
          tmo_err_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    spu_mulred_start     = (state_q == ST_LAUNCH);
    spu_mulred_aequb_sel = (state_q == ST_LAUNCH) && (owner_q == OWN_AEQ);
    spu_mulred_owner     = owner_q;
    spu_mulred_busy      = (state_q != ST_IDLE);
    spu_mulred_exp_done  = (state_q == ST_DONE) &&
                           ((owner_q == OWN_AEQ) || (owner_q == OWN_ANE));
    spu_mulred_mul_done  = (state_q == ST_DONE) && (owner_q == OWN_MUL);
    spu_mulred_abort     = abort_q;
    spu_mulred_tmo_err   = tmo_err_q;
    spu_mulred_ovf_err   = ovf_err_q;
  end

endmodule

// File: tb/tb_spu_mulred_arb.sv
// Directed bench for spu_mulred_arb (watchdog limit shortened to 8 cycles).
module tb_spu_mulred_arb;

  logic       rclk;
  logic       reset;
  logic       se;
  logic       req_a, req_n, req_m, red_done, kill;
  logic       start, sel, busy, exp_done, mul_done, abort, tmo, ovf;
  logic [1:0] owner;

  int n_checks = 0;
  int n_err    = 0;

  spu_mulred_arb #(.TMO_W(10), .TMO_MAX(8)) dut (
    .rclk                           (rclk),
    .reset                          (reset),
    .se                             (se),
    .spu_maexp_start_mulred_aequb   (req_a),
    .spu_maexp_start_mulred_anoteqb (req_n),
    .spu_mamul_start_mulred         (req_m),
    .spu_mared_red_done             (red_done),
    .spu_mactl_kill_op              (kill),
    .spu_mulred_start               (start),
    .spu_mulred_aequb_sel           (sel),
    .spu_mulred_owner               (owner),
    .spu_mulred_busy                (busy),
    .spu_mulred_exp_done            (exp_done),
    .spu_mulred_mul_done            (mul_done),
    .spu_mulred_abort               (abort),
    .spu_mulred_tmo_err             (tmo),
    .spu_mulred_ovf_err             (ovf)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {start, sel, owner, busy, exp_done, mul_done, abort, tmo, ovf};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    se = 1'b0; req_a = 1'b0; req_n = 1'b0; req_m = 1'b0;
    red_done = 1'b0; kill = 1'b0; reset = 1'b1;

    // Single exp op; red_done lands on the 8th BUSY cycle so done must beat timeout
    do_reset();
    chk("rst_outs", outs(), 0);
    req_a = 1'b1; step();              // c1
    req_a = 1'b0;
    chk("c1_start", start, 0);
    chk("c1_busy", busy, 0);
    step();                            // c2
    chk("c2_start", start, 1);
    chk("c2_sel", sel, 1);
    chk("c2_owner", owner, 2'b01);
    chk("c2_busy", busy, 1);
    repeat (8) step();                 // c10
    chk("c10_busy", busy, 1);
    chk("c10_expdone", exp_done, 0);
    red_done = 1'b1; step();           // c11
    red_done = 1'b0;
    chk("c11_expdone", exp_done, 1);
    chk("c11_muldone", mul_done, 0);
    step();                            // c12
    chk("c12_abort", abort, 0);
    chk("c12_tmo", tmo, 0);
    chk("c12_owner", owner, 2'b00);
    chk("c12_busy", busy, 0);

    // Contention / round-robin
    do_reset();
    req_n = 1'b1; req_m = 1'b1; step();  // c1
    req_n = 1'b0; req_m = 1'b0; step();  // c2
    chk("rr1_start", start, 1);
    chk("rr1_owner", owner, 2'b10);
    chk("rr1_sel", sel, 0);
    step(); step();                      // c4
    red_done = 1'b1; step();             // c5
    red_done = 1'b0;
    chk("rr1_expdone", exp_done, 1);
    step();                              // c6
    chk("rr1_idle_start", start, 0);
    step();                              // c7
    chk("rr2_start", start, 1);
    chk("rr2_owner", owner, 2'b11);
    chk("rr2_sel", sel, 0);
    step();                              // c8
    red_done = 1'b1; step();             // c9
    red_done = 1'b0;
    chk("rr2_muldone", mul_done, 1);
    chk("rr2_expdone", exp_done, 0);
    step();                              // c10
    req_a = 1'b1; req_m = 1'b1; step();  // c11
    req_a = 1'b0; req_m = 1'b0; step();  // c12
    chk("rr3_owner", owner, 2'b01);
    chk("rr3_sel", sel, 1);
    step();                              // c13
    red_done = 1'b1; step();             // c14
    red_done = 1'b0; step(); step();     // c16
    chk("rr4_start", start, 1);
    chk("rr4_owner", owner, 2'b11);

    // Kill in BUSY, five cycles after launch
    repeat (5) step();                   // c21
    kill = 1'b1; step();                 // c22
    kill = 1'b0;
    chk("kill_abort", abort, 1);
    chk("kill_busy", busy, 0);
    chk("kill_owner", owner, 2'b00);
    chk("kill_muldone", mul_done, 0);
    step();                              // c23
    chk("kill_abort_1cyc", abort, 0);
    chk("kill_muldone2", mul_done, 0);
    step();                              // c24
    chk("kill_nopend", start, 0);
    // Kill together with red_done
    req_m = 1'b1; step();                // c25
    req_m = 1'b0; step();                // c26
    chk("kd_start", start, 1);
    step(); step();                      // c28
    kill = 1'b1; red_done = 1'b1; step(); // c29
    kill = 1'b0; red_done = 1'b0;
    chk("kd_abort", abort, 1);
    chk("kd_muldone", mul_done, 0);
    chk("kd_busy", busy, 0);
    step();                              // c30
    chk("kd_muldone2", mul_done, 0);

    // Watchdog timeout after 8 BUSY cycles
    req_n = 1'b1; step();                // c31
    req_n = 1'b0; step();                // c32
    chk("wd_start", start, 1);
    repeat (8) step();                   // c40
    chk("wd_busy8", busy, 1);
    chk("wd_abort8", abort, 0);
    step();                              // c41
    chk("wd_abort", abort, 1);
    chk("wd_tmo", tmo, 1);
    chk("wd_busy", busy, 0);
    chk("wd_expdone", exp_done, 0);
    repeat (3) step();
    chk("wd_abort_off", abort, 0);
    chk("wd_tmo_sticky", tmo, 1);
    do_reset();
    chk("wd_rst_outs", outs(), 0);

    // Pulse in the grant cycle: no overrun, second launch
    req_a = 1'b1; step();                // c1 grant cycle, pulse held
    step();                              // c2
    req_a = 1'b0;
    chk("gc_owner", owner, 2'b01);
    chk("gc_ovf", ovf, 0);
    step();                              // c3
    red_done = 1'b1; step();             // c4
    red_done = 1'b0;
    chk("gc_expdone", exp_done, 1);
    step(); step();                      // c6
    chk("gc_start2", start, 1);
    chk("gc_owner2", owner, 2'b01);
    chk("gc_ovf2", ovf, 0);
    step();                              // c7
    red_done = 1'b1; step();             // c8
    red_done = 1'b0; step();             // c9
    chk("gc_idle", busy, 0);

    // Overrun while mamul owns the engine
    req_m = 1'b1; step();                // c10
    req_m = 1'b0; step();                // c11
    chk("ov_owner", owner, 2'b11);
    step();                              // c12
    req_a = 1'b1; step();                // c13
    chk("ov_pre", ovf, 0);
    step();                              // c14
    req_a = 1'b0;
    chk("ov_set", ovf, 1);
    red_done = 1'b1; step();             // c15
    red_done = 1'b0;
    chk("ov_muldone", mul_done, 1);
    step(); step();                      // c17
    chk("ov_launch_a", owner, 2'b01);
    chk("ov_sticky", ovf, 1);

    // Reset in mid-operation
    step(); step();                      // c19 BUSY
    reset = 1'b1; step();                // c20
    reset = 1'b0;
    chk("mr_outs", outs(), 0);
    red_done = 1'b1; step();             // c21
    red_done = 1'b0;
    chk("mr_late_done", outs(), 0);
    step();
    chk("mr_idle", outs(), 0);

    // Kill in IDLE drops pending; kill beats a same-cycle pulse
    req_m = 1'b1; step();
    req_m = 1'b0; kill = 1'b1; step();
    kill = 1'b0;
    chk("ki_abort", abort, 0);
    step();
    chk("ki_nolaunch", start, 0);
    req_a = 1'b1; kill = 1'b1; step();
    req_a = 1'b0; kill = 1'b0; step();
    chk("ki_pulse_killed", start, 0);
    chk("ki_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
